// File: rtl/alu_iter.sv
// alu_iter - multi-cycle integer ALU for the RV32I datapath.
//
// One operation in flight, valid/ready handshake on both sides. ADD, SUB,
// AND, OR, XOR, SLT and SLTU complete in one cycle. SLL/SRL/SRA shift
// iteratively, SHIFT_STEP bits per cycle. Result and flags are registered
// and held until the consumer takes them.
//
// Optional feature macro: ALU_MUL_EN
//   defined   : control 10 = MUL, radix-2 shift-add over WIDTH cycles
//   undefined : control 10 is treated as an unsupported code
//
// Parameters
//   WIDTH       operand/result width (power of two, >= 8)
//   SHIFT_STEP  bits shifted per shift cycle (power of two, 1..WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request
//   in_ready   ALU idle and able to accept
//   a, b       operands; shift amount is b[$clog2(WIDTH)-1:0]
//   control    opcode (0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRA,7 SRL,
//              8 SLT,9 SLTU,10 MUL)
//   out_valid  result and flags valid
//   out_ready  consumer takes the result
//   out        result
//   zero       result is zero (only while out_valid)
//   neg        result sign bit
//   carry      ADD carry-out / SUB borrow, else 0
//   overflow   signed overflow of ADD/SUB, else 0
module alu_iter #(
   parameter int WIDTH      = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             overflow
);

   localparam int AW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRA  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [AW-1:0] CNT_LAST = AW'(WIDTH - 1);
`endif

   // One extra bit so a step equal to WIDTH is representable.
   localparam logic [AW:0] STEP_W = (AW+1)'(SHIFT_STEP);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] res;
   logic [3:0]       op;
   logic [AW:0]      rem;
   logic             carry_flag;
   logic             ovf_flag;
`ifdef ALU_MUL_EN
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [AW-1:0]    cnt;
`endif

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             alu_ovf;
   logic [AW:0]      shamt_in;
   logic             shift_in;
   logic [AW:0]      step;
   logic [WIDTH-1:0] shifted;

   assign shamt_in = {1'b0, b[AW-1:0]};
   assign shift_in = (control == OP_SLL) || (control == OP_SRA) || (control == OP_SRL);

   // Single-cycle result, computed straight from the inputs at the accept
   // edge. Shifts preload the operand; MUL and unsupported codes start at 0.
   always_comb begin
      sum       = {1'b0, a} + {1'b0, b};
      diff      = {1'b0, a} - {1'b0, b};
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (control)
         OP_ADD: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ovf   = (a[WIDTH-1] != sum[WIDTH-1]) && (a[WIDTH-1] == b[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res   = diff[WIDTH-1:0];
            alu_carry = diff[WIDTH];
            alu_ovf   = (a[WIDTH-1] != diff[WIDTH-1]) && (a[WIDTH-1] != b[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_SLL, OP_SRA, OP_SRL: alu_res = a;
         OP_SLT:  alu_res[0] = $signed(a) < $signed(b);
         OP_SLTU: alu_res[0] = a < b;
         default: alu_res = '0;
      endcase
   end

   // One shift iteration: the last step may be shorter than SHIFT_STEP.
   always_comb begin
      step = (rem < STEP_W) ? rem : STEP_W;
      case (op)
         OP_SLL:  shifted = res << step;
         OP_SRL:  shifted = res >> step;
         default: shifted = $signed(res) >>> step;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic. A zero-length shift skips EXEC entirely.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (shift_in && (shamt_in != '0)) state_next = EXEC;
`ifdef ALU_MUL_EN
               else if (control == OP_MUL)     state_next = EXEC;
`endif
               else                            state_next = DONE;
            end
         end
         EXEC: begin
`ifdef ALU_MUL_EN
            if (op == OP_MUL) begin
               if (cnt == CNT_LAST) state_next = DONE;
            end else
`endif
            if (rem <= STEP_W) state_next = DONE;
         end
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Datapath: capture on accept, iterate in EXEC, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res        <= '0;
         op         <= '0;
         rem        <= '0;
         carry_flag <= 1'b0;
         ovf_flag   <= 1'b0;
`ifdef ALU_MUL_EN
         mcand      <= '0;
         mplier     <= '0;
         cnt        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op         <= control;
                  res        <= alu_res;
                  carry_flag <= alu_carry;
                  ovf_flag   <= alu_ovf;
                  rem        <= shamt_in;
`ifdef ALU_MUL_EN
                  mcand      <= a;
                  mplier     <= b;
                  cnt        <= '0;
`endif
               end
            end
            EXEC: begin
`ifdef ALU_MUL_EN
               if (op == OP_MUL) begin
                  if (mplier[0]) res <= res + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 1'b1;
               end else begin
`else
               begin
`endif
                  res <= shifted;
                  rem <= rem - step;
               end
            end
            default: ;
         endcase
      end
   end

   // zero is qualified by DONE so it reads 0 out of reset and mid-operation.
   assign out      = res;
   assign zero     = (state == DONE) && (res == '0);
   assign neg      = res[WIDTH-1];
   assign carry    = carry_flag;
   assign overflow = ovf_flag;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter - self-checking bench for alu_iter (WIDTH=32, SHIFT_STEP=1).
// Random operations are checked against an arithmetic reference model;
// directed operations pin known results, latencies, hold and reset behaviour.
module tb_alu_iter;

   localparam int W    = 32;
   localparam int STEP = 1;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b1;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a         = '0;
   logic [W-1:0] b         = '0;
   logic [3:0]   control   = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out;
   logic         zero;
   logic         neg;
   logic         carry;
   logic         overflow;

   int vectors     = 0;
   int miscompares = 0;

   logic         exp_live = 1'b0;
   logic [W-1:0] exp_out  = '0;
   logic         exp_carry = 1'b0;
   logic         exp_ovf   = 1'b0;
   int           exp_lat   = 0;

   logic [W-1:0] last_out;
   logic         last_zero;
   logic         last_neg;
   logic         last_carry;
   logic         last_ovf;
   int           last_lat;

   alu_iter #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .control   (control),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zero      (zero),
      .neg       (neg),
      .carry     (carry),
      .overflow  (overflow)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] required);
      vectors++;
      if (actual !== required) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
      end
   endtask

   // Reference model: plain arithmetic on 64-bit integers.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [3:0] mc, output logic [W-1:0] r,
                                 output logic c, output logic v, output int lat);
      longint ua   = longint'({32'h0, ma});
      longint ub   = longint'({32'h0, mb});
      longint sa   = longint'($signed(ma));
      longint sb   = longint'($signed(mb));
      longint maxs = 2147483647;
      longint mins = -maxs - 1;
      longint t;
      int     amt  = int'(mb[4:0]);
      r = '0; c = 1'b0; v = 1'b0; lat = 1;
      case (mc)
         4'd0: begin
            t = ua + ub; r = t[31:0]; c = t[32];
            t = sa + sb; v = (t > maxs) || (t < mins);
         end
         4'd1: begin
            t = ua - ub; r = t[31:0]; c = (ua < ub);
            t = sa - sb; v = (t > maxs) || (t < mins);
         end
         4'd2: r = ma & mb;
         4'd3: r = ma | mb;
         4'd4: r = ma ^ mb;
         4'd5: begin r = ma << amt; lat = 1 + (amt + STEP - 1) / STEP; end
         4'd6: begin r = $signed(ma) >>> amt; lat = 1 + (amt + STEP - 1) / STEP; end
         4'd7: begin r = ma >> amt; lat = 1 + (amt + STEP - 1) / STEP; end
         4'd8: r = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
         4'd9: r = (ma < mb) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
         4'd10: begin t = ua * ub; r = t[31:0]; lat = W + 1; end
`endif
         default: r = '0;
      endcase
   endfunction

   // Every cycle a result is presented, it must match the model.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (!exp_live) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL spurious_out_valid: got 1, required 0");
         end else begin
            checkOutput("out",      out,           exp_out);
            checkOutput("zero",     32'(zero),     32'(exp_out == '0));
            checkOutput("neg",      32'(neg),      32'(exp_out[W-1]));
            checkOutput("carry",    32'(carry),    32'(exp_carry));
            checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
         end
      end
   end

   // Issue one operation, measure latency, hold DONE for 'hold' cycles while
   // driving junk requests, then release and check the return to IDLE.
   task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                input logic [3:0] tc, input int hold);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) begin
         vectors++; miscompares++;
         $display("[TB] FAIL in_ready_timeout: got 0, required 1");
         return;
      end
      model(ta, tb, tc, exp_out, exp_carry, exp_ovf, exp_lat);
      a = ta; b = tb; control = tc; in_valid = 1'b1;
      exp_live = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; control = 4'($urandom);
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 200);
      if (!out_valid) begin
         vectors++; miscompares++;
         $display("[TB] FAIL out_valid_timeout: got 0, required 1");
         exp_live = 1'b0;
         return;
      end
      last_lat = n;
      checkOutput("latency", 32'(n), 32'(exp_lat));
      last_out = out; last_zero = zero; last_neg = neg;
      last_carry = carry; last_ovf = overflow;
      for (int i = 0; i < hold; i++) begin
         checkOutput("in_ready_in_done", 32'(in_ready), 32'd0);
         in_valid = 1'b1; a = $urandom; b = $urandom; control = 4'($urandom);
         @(negedge clk);
      end
      // Release with a request still asserted: it must not be accepted now.
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; exp_live = 1'b0;
      checkOutput("out_valid_after_release", 32'(out_valid), 32'd0);
      checkOutput("in_ready_after_release",  32'(in_ready),  32'd1);
      in_valid = 1'b0;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      // Reset state.
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_out",       out,             32'd0);
      checkOutput("reset_out_valid", 32'(out_valid),  32'd0);
      checkOutput("reset_zero",      32'(zero),       32'd0);
      checkOutput("reset_neg",       32'(neg),        32'd0);
      checkOutput("reset_carry",     32'(carry),      32'd0);
      checkOutput("reset_overflow",  32'(overflow),   32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

      // Arithmetic boundary cases.
      applyStimulus(32'h7FFFFFFF, 32'd1, 4'd0, 0);
      checkOutput("lit_add_out", last_out,            32'h80000000);
      checkOutput("lit_add_ovf", 32'(last_ovf),       32'd1);
      checkOutput("lit_add_neg", 32'(last_neg),       32'd1);
      checkOutput("lit_add_cy",  32'(last_carry),     32'd0);
      checkOutput("lit_add_lat", 32'(last_lat),       32'd1);
      applyStimulus(32'd0, 32'd1, 4'd1, 0);
      checkOutput("lit_sub_out", last_out,            32'hFFFFFFFF);
      checkOutput("lit_sub_cy",  32'(last_carry),     32'd1);
      checkOutput("lit_sub_ovf", 32'(last_ovf),       32'd0);
      applyStimulus(32'hFFFFFFFF, 32'd1, 4'd8, 0);
      checkOutput("lit_slt_out", last_out,            32'd1);
      applyStimulus(32'hFFFFFFFF, 32'd1, 4'd9, 0);
      checkOutput("lit_sltu_out", last_out,           32'd0);

      // Shifts.
      applyStimulus(32'h80000000, 32'd31, 4'd6, 0);
      checkOutput("lit_sra_out", last_out,            32'hFFFFFFFF);
      checkOutput("lit_sra_lat", 32'(last_lat),       32'd32);
      applyStimulus(32'h12345678, 32'd0, 4'd5, 0);
      checkOutput("lit_sll0_out", last_out,           32'h12345678);
      checkOutput("lit_sll0_lat", 32'(last_lat),      32'd1);

      // Backpressure: hold DONE for 5 cycles with junk requests.
      applyStimulus(32'h0000F00D, 32'h00000FF0, 4'd4, 5);
      checkOutput("lit_xor_out", last_out,            32'h0000FFFD);

      // Opcode 10: multiplier when enabled, unsupported otherwise.
`ifdef ALU_MUL_EN
      applyStimulus(32'h0000FFFF, 32'h00010001, 4'd10, 0);
      checkOutput("lit_mul_out", last_out,            32'hFFFFFFFF);
      checkOutput("lit_mul_lat", 32'(last_lat),       32'd33);
`else
      applyStimulus(32'h0000FFFF, 32'h00010001, 4'd10, 0);
      checkOutput("lit_op10_out",  last_out,          32'd0);
      checkOutput("lit_op10_zero", 32'(last_zero),    32'd1);
      checkOutput("lit_op10_lat",  32'(last_lat),     32'd1);
`endif
      applyStimulus(32'hDEADBEEF, 32'h1, 4'd13, 1);

      // Reset during the third SRL shift cycle.
      @(negedge clk);
      a = 32'hF0F0F0F0; b = 32'd20; control = 4'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("srl_busy_out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("midop_reset_out",       out,            32'd0);
      checkOutput("midop_reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midop_reset_zero",      32'(zero),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
         checkOutput("post_reset_in_ready",  32'(in_ready),  32'd1);
      end
      applyStimulus(32'd2, 32'd3, 4'd0, 0);
      checkOutput("lit_add_after_reset", last_out, 32'd5);

      // Randomised operations with some boundary operands.
      for (int i = 0; i < 60; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h80000000;
            1: ra = 32'h7FFFFFFF;
            2: rb = ra;
            3: rb = 32'hFFFFFFFF;
            default: ;
         endcase
         applyStimulus(ra, rb, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
